// File: rtl/e203_exu_fpu_fmis_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : e203_exu_fpu_fmis_ctrl
// Description : Sequencer between the FPU misc-op issue port and the FMIS
//               sub-units (sgnj, mv). Accepts one op at a time, dispatches it
//               to the one-hot selected unit, collects the result and returns
//               it with its itag on a valid/ready write-back port. Handles
//               flush and answers illegal selects with an error response.
// Options     : E203_FMIS_CTRL_TIMEOUT_EN - enables the dispatch timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module e203_exu_fpu_fmis_ctrl #(
  parameter int XLEN    = 32,
  parameter int ITAG_W  = 2,
  parameter int TMO_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [XLEN-1:0]   req_rs2,
  input  logic [1:0]        req_sel,
  input  logic [1:0]        req_flag,
  input  logic [ITAG_W-1:0] req_itag,
  input  logic              flush_pulse,
  output logic [XLEN-1:0]   u_rs1,
  output logic [XLEN-1:0]   u_rs2,
  output logic [1:0]        u_flag,
  output logic              sgnj_i_valid,
  input  logic              sgnj_i_ready,
  input  logic              sgnj_o_valid,
  output logic              sgnj_o_ready,
  input  logic [XLEN-1:0]   sgnj_o_wdat,
  output logic              mv_i_valid,
  input  logic              mv_i_ready,
  input  logic              mv_o_valid,
  output logic              mv_o_ready,
  input  logic [XLEN-1:0]   mv_o_wdat,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_wdat,
  output logic [ITAG_W-1:0] rsp_itag,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DISP  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [XLEN-1:0]     r_rs1;
  logic [XLEN-1:0]     r_rs2;
  logic [1:0]          r_flag;
  logic [1:0]          r_sel;
  logic [ITAG_W-1:0]   r_itag;
  logic [XLEN-1:0]     r_rsp_wdat;
  logic                r_rsp_err;

  logic                w_accept;
  logic                w_set_err;
  logic                w_cap_res;
  logic                w_req_legal;
  logic                w_unit_i_ready;
  logic                w_unit_o_valid;
  logic [XLEN-1:0]     w_unit_o_wdat;
  logic                w_result_phase;
  logic                w_tmo_hit;

  // The timeout counter is 4 bits wide, so the limit must fit in 1..15.
  if (TMO_CYC < 1 || TMO_CYC > 15) begin : g_tmo_range_chk
    $error("TMO_CYC must be in 1..15");
  end

  // Legal selects are exactly one-hot.
  assign w_req_legal    = ^req_sel;

  // Mux the selected unit's handshake/result; sel is one-hot whenever a unit is engaged.
  assign w_unit_i_ready = r_sel[0] ? sgnj_i_ready : mv_i_ready;
  assign w_unit_o_valid = r_sel[0] ? sgnj_o_valid : mv_o_valid;
  assign w_unit_o_wdat  = r_sel[0] ? sgnj_o_wdat  : mv_o_wdat;

  assign w_result_phase = (r_state == ST_WAIT) || (r_state == ST_DRAIN);

  assign req_ready      = (r_state == ST_IDLE) && !flush_pulse;
  assign sgnj_i_valid   = (r_state == ST_DISP) && r_sel[0];
  assign mv_i_valid     = (r_state == ST_DISP) && r_sel[1];
  assign sgnj_o_ready   = w_result_phase && r_sel[0];
  assign mv_o_ready     = w_result_phase && r_sel[1];
  assign rsp_valid      = (r_state == ST_RESP);
  assign busy           = (r_state != ST_IDLE);

  assign u_rs1          = r_rs1;
  assign u_rs2          = r_rs2;
  assign u_flag         = r_flag;
  assign rsp_wdat       = r_rsp_wdat;
  assign rsp_itag       = r_itag;
  assign rsp_err        = r_rsp_err;

`ifdef E203_FMIS_CTRL_TIMEOUT_EN
  localparam logic [3:0] c_tmo_last = 4'(TMO_CYC - 1);

  logic [3:0] r_tmo_cnt;

  // The timeout fires on the TMO_CYC-th consecutive stalled DISP cycle, so
  // i_valid is seen high for exactly TMO_CYC cycles before the error response.
  assign w_tmo_hit = (r_state == ST_DISP) && !w_unit_i_ready && (r_tmo_cnt == c_tmo_last);

  // Count stalled dispatch cycles; restart on every entry into DISP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= 4'd0;
    end else if ((w_state_nxt == ST_DISP) && (r_state != ST_DISP)) begin
      r_tmo_cnt <= 4'd0;
    end else if ((r_state == ST_DISP) && !w_unit_i_ready) begin
      r_tmo_cnt <= r_tmo_cnt + 4'd1;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; flush is checked first in every busy state.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_set_err   = 1'b0;
    w_cap_res   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          w_accept = 1'b1;
          if (w_req_legal) begin
            w_state_nxt = ST_DISP;
          end else begin
            w_state_nxt = ST_RESP;
            w_set_err   = 1'b1;
          end
        end
      end
      ST_DISP: begin
        if (flush_pulse) begin
          // An issue handshake in the flush cycle still hands the op to the
          // unit, so its result must be drained before going idle.
          w_state_nxt = w_unit_i_ready ? ST_DRAIN : ST_IDLE;
        end else if (w_unit_i_ready) begin
          w_state_nxt = ST_WAIT;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_RESP;
          w_set_err   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (flush_pulse) begin
          w_state_nxt = w_unit_o_valid ? ST_IDLE : ST_DRAIN;
        end else if (w_unit_o_valid) begin
          w_state_nxt = ST_RESP;
          w_cap_res   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (w_unit_o_valid) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (flush_pulse || rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand/tag capture on accept; response data/error capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_flag     <= 2'b00;
      r_sel      <= 2'b00;
      r_itag     <= '0;
      r_rsp_wdat <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rs1  <= req_rs1;
        r_rs2  <= req_rs2;
        r_flag <= req_flag;
        r_sel  <= req_sel;
        r_itag <= req_itag;
      end
      if (w_set_err) begin
        r_rsp_err  <= 1'b1;
        r_rsp_wdat <= '0;
      end else if (w_cap_res) begin
        r_rsp_err  <= 1'b0;
        r_rsp_wdat <= w_unit_o_wdat;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_e203_exu_fpu_fmis_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_e203_exu_fpu_fmis_ctrl
// Description : Directed self-checking bench for e203_exu_fpu_fmis_ctrl with
//               behavioural sgnj/mv unit models and a write-back scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_e203_exu_fpu_fmis_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_rs1, req_rs2;
  logic [1:0]  req_sel, req_flag, req_itag;
  logic        flush_pulse;
  logic [31:0] u_rs1, u_rs2;
  logic [1:0]  u_flag;
  logic        sgnj_i_valid, sgnj_i_ready, sgnj_o_valid, sgnj_o_ready;
  logic [31:0] sgnj_o_wdat;
  logic        mv_i_valid, mv_i_ready, mv_o_valid, mv_o_ready;
  logic [31:0] mv_o_wdat;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_wdat;
  logic [1:0]  rsp_itag;
  logic        rsp_err, busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] wdat;
    logic [1:0]  itag;
    logic        err;
  } exp_t;
  exp_t sb[$];

  // Unit behaviour knobs.
  int sgnj_dly = 0;
  int sgnj_cnt;
  logic sgnj_pend;
  int mv_cnt;

  always #5 clk = ~clk;

  e203_exu_fpu_fmis_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_sel(req_sel),
    .req_flag(req_flag), .req_itag(req_itag), .flush_pulse(flush_pulse),
    .u_rs1(u_rs1), .u_rs2(u_rs2), .u_flag(u_flag),
    .sgnj_i_valid(sgnj_i_valid), .sgnj_i_ready(sgnj_i_ready),
    .sgnj_o_valid(sgnj_o_valid), .sgnj_o_ready(sgnj_o_ready), .sgnj_o_wdat(sgnj_o_wdat),
    .mv_i_valid(mv_i_valid), .mv_i_ready(mv_i_ready),
    .mv_o_valid(mv_o_valid), .mv_o_ready(mv_o_ready), .mv_o_wdat(mv_o_wdat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wdat(rsp_wdat),
    .rsp_itag(rsp_itag), .rsp_err(rsp_err), .busy(busy)
  );

  function automatic logic [31:0] sgnj_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] f);
    case (f)
      2'b00:   return {b[31], a[30:0]};
      2'b01:   return {~b[31], a[30:0]};
      default: return {a[31] ^ b[31], a[30:0]};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // sgnj unit model: result sgnj_dly cycles after the nominal 1-cycle latency.
  always @(posedge clk) begin
    if (rst) begin
      sgnj_o_valid <= 1'b0;
      sgnj_o_wdat  <= 32'h0;
      sgnj_pend    <= 1'b0;
      sgnj_cnt     <= 0;
    end else begin
      if (sgnj_o_valid && sgnj_o_ready) sgnj_o_valid <= 1'b0;
      if (sgnj_i_valid && sgnj_i_ready) begin
        sgnj_o_wdat <= sgnj_fn(u_rs1, u_rs2, u_flag);
        if (sgnj_dly == 0) sgnj_o_valid <= 1'b1;
        else begin
          sgnj_pend <= 1'b1;
          sgnj_cnt  <= sgnj_dly - 1;
        end
      end else if (sgnj_pend) begin
        if (sgnj_cnt == 0) begin
          sgnj_o_valid <= 1'b1;
          sgnj_pend    <= 1'b0;
        end else sgnj_cnt <= sgnj_cnt - 1;
      end
    end
  end

  // mv unit model: 1-cycle latency, result is rs1.
  always @(posedge clk) begin
    if (rst) begin
      mv_o_valid <= 1'b0;
      mv_o_wdat  <= 32'h0;
      mv_cnt     <= 0;
    end else begin
      if (mv_o_valid && mv_o_ready) mv_o_valid <= 1'b0;
      if (mv_i_valid && mv_i_ready) begin
        mv_o_wdat  <= u_rs1;
        mv_o_valid <= 1'b1;
        mv_cnt     <= mv_cnt + 1;
      end
    end
  end

  // Scoreboard: every completed write-back must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready && !flush_pulse) begin
      chk("wb_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_wdat", 64'(rsp_wdat), 64'(e.wdat));
        chk("wb_itag", 64'(rsp_itag), 64'(e.itag));
        chk("wb_err",  64'(rsp_err),  64'(e.err));
      end
    end
  end

  task automatic push_exp(input logic [31:0] w, input logic [1:0] t, input logic er);
    exp_t e;
    e.wdat = w; e.itag = t; e.err = er;
    sb.push_back(e);
  endtask

  task automatic drive_req(input logic [1:0] sel, input logic [1:0] flag,
                           input logic [31:0] a, input logic [31:0] b, input logic [1:0] tag);
    req_valid = 1'b1; req_sel = sel; req_flag = flag;
    req_rs1 = a; req_rs2 = b; req_itag = tag;
  endtask

  // Whole op with scoreboard expectation and a bounded wait for completion.
  task automatic run_op(input logic [1:0] sel, input logic [1:0] flag,
                        input logic [31:0] a, input logic [31:0] b, input logic [1:0] tag,
                        input logic [31:0] ew, input logic ee);
    int n;
    push_exp(ew, tag, ee);
    drive_req(sel, flag, a, b, tag);
    cyc();
    req_valid = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      cyc();
      n++;
    end
    chk("op_done", 64'(busy), 64'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_sel = '0;
    req_flag = '0; req_itag = '0; flush_pulse = 1'b0;
    sgnj_i_ready = 1'b1; mv_i_ready = 1'b1; rsp_ready = 1'b1;
    cyc(); cyc();
    // Reset state
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy",      64'(busy), 64'd0);
    chk("rst_ivalid",    64'({sgnj_i_valid, mv_i_valid, sgnj_o_ready, mv_o_ready}), 64'd0);
    chk("rst_regs",      64'({u_rs1, u_rs2, u_flag, rsp_itag, rsp_err}), 64'd0);
    chk("rst_rsp_wdat",  64'(rsp_wdat), 64'd0);
    rst = 1'b0;
    cyc();

    // 1: sgnjn latency T1/T2/T3
    push_exp(32'hBF800000, 2'd2, 1'b0);
    drive_req(2'b01, 2'b01, 32'h3F800000, 32'h0, 2'd2);
    #1 chk("t1_req_ready", 64'(req_ready), 64'd1);
    cyc(); req_valid = 1'b0;                                   // T1
    chk("t1_T1_ivalid", 64'({sgnj_i_valid, mv_i_valid}), 64'b10);
    chk("t1_T1_u_rs1",  64'(u_rs1), 64'h3F800000);
    chk("t1_T1_u_flag", 64'(u_flag), 64'd1);
    chk("t1_T1_rsp",    64'(rsp_valid), 64'd0);
    cyc();                                                     // T2
    chk("t1_T2_oready", 64'({sgnj_o_ready, mv_o_ready}), 64'b10);
    chk("t1_T2_rsp",    64'(rsp_valid), 64'd0);
    cyc();                                                     // T3
    chk("t1_T3_rsp",    64'(rsp_valid), 64'd1);
    chk("t1_T3_wdat",   64'(rsp_wdat), 64'hBF800000);
    chk("t1_T3_itag",   64'(rsp_itag), 64'd2);
    chk("t1_T3_err",    64'(rsp_err), 64'd0);
    cyc();
    chk("t1_T4_idle",   64'({rsp_valid, req_ready}), 64'b01);

    // 2: mv with write-back stalled 5 cycles
    rsp_ready = 1'b0;
    push_exp(32'h12345678, 2'd3, 1'b0);
    drive_req(2'b10, 2'b00, 32'h12345678, 32'hDEADBEEF, 2'd3);
    cyc(); req_valid = 1'b0;
    chk("t2_ivalid", 64'({sgnj_i_valid, mv_i_valid}), 64'b01);
    cyc();
    chk("t2_oready", 64'({sgnj_o_ready, mv_o_ready}), 64'b01);
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("t2_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t2_hold_data",  64'({rsp_wdat, rsp_itag, rsp_err}), {29'd0, 32'h12345678, 2'd3, 1'b0});
      chk("t2_hold_rdy",   64'(req_ready), 64'd0);
      cyc();
    end
    rsp_ready = 1'b1;
    #1 chk("t2_release_rdy", 64'(req_ready), 64'd0);
    cyc();
    chk("t2_after_rdy", 64'({rsp_valid, req_ready}), 64'b01);

    // 3: illegal selects 11 and 00
    push_exp(32'h0, 2'd1, 1'b1);
    drive_req(2'b11, 2'b00, 32'hFFFFFFFF, 32'h1, 2'd1);
    cyc(); req_valid = 1'b0;
    chk("t3_no_issue", 64'({sgnj_i_valid, mv_i_valid}), 64'd0);
    chk("t3_rsp",      64'({rsp_valid, rsp_err}), 64'b11);
    chk("t3_wdat",     64'(rsp_wdat), 64'd0);
    cyc();
    run_op(2'b00, 2'b00, 32'h55, 32'h66, 2'd0, 32'h0, 1'b1);

    // sgnj / sgnjx / mv functional patterns
    run_op(2'b01, 2'b00, 32'h40490FDB, 32'h80000000, 2'd1, 32'hC0490FDB, 1'b0);
    run_op(2'b01, 2'b10, 32'hC0000000, 32'h80000000, 2'd2, 32'h40000000, 1'b0);
    run_op(2'b10, 2'b11, 32'hA5A5A5A5, 32'h0, 2'd3, 32'hA5A5A5A5, 1'b0);

    // 4: flush in WAIT, late result drained and dropped
    sgnj_dly = 3;
    drive_req(2'b01, 2'b00, 32'h3F800000, 32'h80000000, 2'd0);
    cyc(); req_valid = 1'b0;                                   // T1 DISP
    cyc();                                                     // T2 WAIT
    flush_pulse = 1'b1;
    #1 chk("t4_pre_ovalid", 64'(sgnj_o_valid), 64'd0);
    cyc(); flush_pulse = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t4_drain", 64'({busy, sgnj_o_ready, rsp_valid}), 64'b110);
      cyc();
    end
    chk("t4_idle", 64'({busy, rsp_valid, req_ready, sgnj_o_valid}), 64'b0010);
    sgnj_dly = 0;

    // 5: flush in RESP with rsp_ready high drops the write-back
    drive_req(2'b10, 2'b00, 32'hCAFEF00D, 32'h0, 2'd1);
    cyc(); req_valid = 1'b0;
    cyc(); cyc();
    chk("t5_resp", 64'(rsp_valid), 64'd1);
    flush_pulse = 1'b1;
    cyc(); flush_pulse = 1'b0;
    #1 chk("t5_idle", 64'({rsp_valid, busy, req_ready}), 64'b001);
    // flush in IDLE blocks accept
    flush_pulse = 1'b1;
    drive_req(2'b01, 2'b00, 32'h1, 32'h2, 2'd2);
    #1 chk("t5_idle_flush_rdy", 64'(req_ready), 64'd0);
    cyc(); req_valid = 1'b0; flush_pulse = 1'b0;
    chk("t5_no_accept", 64'(busy), 64'd0);

    // Flush in DISP: without i_ready -> IDLE, with i_ready -> DRAIN
    sgnj_i_ready = 1'b0;
    drive_req(2'b01, 2'b00, 32'h1, 32'h2, 2'd2);
    cyc(); req_valid = 1'b0; flush_pulse = 1'b1;
    cyc(); flush_pulse = 1'b0;
    chk("disp_flush_idle", 64'({busy, sgnj_i_valid}), 64'd0);
    sgnj_i_ready = 1'b1;
    drive_req(2'b01, 2'b00, 32'h1, 32'h2, 2'd2);
    cyc(); req_valid = 1'b0; flush_pulse = 1'b1;
    cyc(); flush_pulse = 1'b0;
    chk("disp_flush_drain", 64'({busy, sgnj_o_ready, rsp_valid}), 64'b110);
    cyc();
    chk("disp_drain_done", 64'({busy, rsp_valid}), 64'd0);

    // Reset mid-op
    sgnj_i_ready = 1'b0;
    drive_req(2'b01, 2'b00, 32'h7777, 32'h2, 2'd3);
    cyc(); req_valid = 1'b0; rst = 1'b1;
    cyc(); rst = 1'b0;
    chk("midrst", 64'({busy, sgnj_i_valid, rsp_valid}), 64'd0);
    chk("midrst_u_rs1", 64'(u_rs1), 64'd0);
    sgnj_i_ready = 1'b1;

    // 6: stuck i_ready
    sgnj_i_ready = 1'b0;
`ifdef E203_FMIS_CTRL_TIMEOUT_EN
    push_exp(32'h0, 2'd2, 1'b1);
    drive_req(2'b01, 2'b01, 32'h3F800000, 32'h0, 2'd2);
    cyc(); req_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      chk("t6_ivalid", 64'({sgnj_i_valid, rsp_valid}), 64'b10);
      cyc();
    end
    chk("t6_tmo", 64'({sgnj_i_valid, rsp_valid, rsp_err}), 64'b011);
    chk("t6_wdat", 64'(rsp_wdat), 64'd0);
    cyc();
    chk("t6_idle", 64'(busy), 64'd0);
`else
    drive_req(2'b01, 2'b01, 32'h3F800000, 32'h0, 2'd2);
    cyc(); req_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk("t6_wait", 64'({sgnj_i_valid, rsp_valid}), 64'b10);
      cyc();
    end
    flush_pulse = 1'b1;
    cyc(); flush_pulse = 1'b0;
    chk("t6_idle", 64'(busy), 64'd0);
`endif
    sgnj_i_ready = 1'b1;

    cyc(); cyc();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
